ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe.sv | 169 ++++++++++++++++
 tb/tb_ctrl_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ----------------------------------------------------------------------------
// ctrl_pipe
// Control pipeline that carries decoded instruction control from decode through
// STAGES stages (stage 0 = execute, STAGES-1 = writeback). Each stage holds
// {ctrl, valid, we, load, cond, not, rd, taken_q}. The block also resolves
// conditional branches in stage 0 and detects load-use hazards against decode.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : asynchronous active-low reset, clears every stage
//   d_ctrl     : opaque decoded control word (CW bits)
//   d_valid    : decode slot holds a real instruction
//   d_rd/rs1/rs2 : destination / source register addresses (RW bits)
//   d_rs_use   : bit0 = rs1 is read, bit1 = rs2 is read
//   d_we, d_load, d_cond, d_not : reg write, load, conditional branch, inverted cond
//   cmp_true   : ALU compare result for the instruction in stage 0
//   stall      : per-stage hold request (bit k = stage k)
//   flush      : per-stage kill request (bit k = stage k)
//   ctrl_out   : stage k control word at [k*CW +: CW]
//   valid_out  : per-stage valid
//   we_out     : per-stage register write, qualified by valid
//   rd_out     : stage k destination at [k*RW +: RW]
//   taken      : stage 0 conditional branch resolved taken (combinational)
//   taken_q    : taken flag travelling with each stage, bit 0 always 0
//   load_use   : load-use hazard, asks decode/fetch to hold (combinational)
// ----------------------------------------------------------------------------
module ctrl_pipe #(
   parameter int STAGES = 3,
   parameter int CW     = 24,
   parameter int RW     = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [CW-1:0]        d_ctrl,
   input  logic                 d_valid,
   input  logic [RW-1:0]        d_rd,
   input  logic [RW-1:0]        d_rs1,
   input  logic [RW-1:0]        d_rs2,
   input  logic [1:0]           d_rs_use,
   input  logic                 d_we,
   input  logic                 d_load,
   input  logic                 d_cond,
   input  logic                 d_not,
   input  logic                 cmp_true,
   input  logic [STAGES-1:0]    stall,
   input  logic [STAGES-1:0]    flush,
   output logic [STAGES*CW-1:0] ctrl_out,
   output logic [STAGES-1:0]    valid_out,
   output logic [STAGES-1:0]    we_out,
   output logic [STAGES*RW-1:0] rd_out,
   output logic                 taken,
   output logic [STAGES-1:0]    taken_q,
   output logic                 load_use
);

   typedef struct packed {
      logic [CW-1:0] ctrl;
      logic          valid;
      logic          we;
      logic          load;
      logic          cond;
      logic          neg;
      logic [RW-1:0] rd;
      logic          tq;
   } stage_t;

   stage_t [STAGES-1:0] stage_q;
   stage_t [STAGES-1:0] stage_d;
   stage_t [STAGES-1:0] src_s;
   logic   [STAGES-1:0] eff_stall_s;
   logic                taken_s;
   logic                load_use_s;
   logic                unused_s;

   // Effective hold: a stall anywhere downstream freezes every stage above it.
   always_comb begin
      eff_stall_s = {STAGES{1'b0}};
      for (int k = 0; k < STAGES; k++) begin
         eff_stall_s[k] = |(stall >> k);
      end
   end

   // Branch resolution and load-use hazard against the instruction in stage 0.
   always_comb begin
      taken_s    = stage_q[0].valid & stage_q[0].cond & (cmp_true ^ stage_q[0].neg);
      load_use_s = 1'b0;
      // Register 0 is hard-wired, so a load targeting it can never create a hazard.
      if (d_valid && stage_q[0].valid && stage_q[0].load && stage_q[0].we &&
          (stage_q[0].rd != {RW{1'b0}})) begin
         load_use_s = (d_rs_use[0] && (d_rs1 == stage_q[0].rd)) ||
                      (d_rs_use[1] && (d_rs2 == stage_q[0].rd));
      end else begin
         load_use_s = 1'b0;
      end
   end

   // What each stage would load if it advances this edge.
   always_comb begin
      src_s = '0;
      if (d_valid && !load_use_s) begin
         src_s[0].ctrl  = d_ctrl;
         src_s[0].valid = 1'b1;
         src_s[0].we    = d_we;
         src_s[0].load  = d_load;
         src_s[0].cond  = d_cond;
         src_s[0].neg   = d_not;
         src_s[0].rd    = d_rd;
         src_s[0].tq    = 1'b0;
      end else begin
         src_s[0] = '0;
      end
      for (int k = 1; k < STAGES; k++) begin
         // Upstream stage is held: pass a bubble so the held instruction is not duplicated.
         if (eff_stall_s[k-1]) begin
            src_s[k] = '0;
         end else begin
            src_s[k] = stage_q[k-1];
            // Stage 1 captures the live branch result; later stages just carry it.
            src_s[k].tq = (k == 1) ? taken_s : stage_q[k-1].tq;
         end
      end
   end

   // Per-stage next state: flush beats hold, hold beats advance.
   always_comb begin
      stage_d = stage_q;
      for (int k = 0; k < STAGES; k++) begin
         if (flush[k]) begin
            stage_d[k] = '0;
         end else if (eff_stall_s[k]) begin
            stage_d[k] = stage_q[k];
         end else begin
            stage_d[k] = src_s[k];
         end
      end
   end

   // Stage registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   // Flatten stage registers onto the output buses.
   always_comb begin
      ctrl_out  = {(STAGES*CW){1'b0}};
      valid_out = {STAGES{1'b0}};
      we_out    = {STAGES{1'b0}};
      rd_out    = {(STAGES*RW){1'b0}};
      taken_q   = {STAGES{1'b0}};
      for (int k = 0; k < STAGES; k++) begin
         ctrl_out[k*CW +: CW] = stage_q[k].ctrl;
         valid_out[k]         = stage_q[k].valid;
         we_out[k]            = stage_q[k].valid & stage_q[k].we;
         rd_out[k*RW +: RW]   = stage_q[k].rd;
         taken_q[k]           = (k == 0) ? 1'b0 : stage_q[k].tq;
      end
      taken    = taken_s;
      load_use = load_use_s;
   end

   // Fields with no consumer: writeback-stage hazard/branch bits and stage 0 taken slot.
   assign unused_s = ^{stage_q[STAGES-1].load, stage_q[STAGES-1].cond,
                       stage_q[STAGES-1].neg, stage_q[0].tq};

endmodule

// File: tb/tb_ctrl_pipe.sv
// ----------------------------------------------------------------------------
// tb_ctrl_pipe
// Directed scoreboard bench for ctrl_pipe. Stimulus pushes hand-computed
// expectations tagged with the clock edge they belong to; a monitor on the
// falling edge pops every expectation due for the current edge and compares.
// ----------------------------------------------------------------------------
module tb_ctrl_pipe;
   localparam int STAGES = 3;
   localparam int CW     = 24;
   localparam int RW     = 5;

   localparam int SEL_VALID = 0;
   localparam int SEL_WE    = 1;
   localparam int SEL_RD    = 2;
   localparam int SEL_CTRL  = 3;
   localparam int SEL_TQ    = 4;
   localparam int SEL_TAKEN = 5;
   localparam int SEL_LU    = 6;
   localparam int SEL_RD2   = 7;
   localparam int SEL_WE2   = 8;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [CW-1:0]        d_ctrl;
   logic                 d_valid;
   logic [RW-1:0]        d_rd, d_rs1, d_rs2;
   logic [1:0]           d_rs_use;
   logic                 d_we, d_load, d_cond, d_not;
   logic                 cmp_true;
   logic [STAGES-1:0]    stall, flush;
   logic [STAGES*CW-1:0] ctrl_out;
   logic [STAGES-1:0]    valid_out, we_out, taken_q;
   logic [STAGES*RW-1:0] rd_out;
   logic                 taken, load_use;

   typedef struct {
      int           cyc;
      string        nm;
      int           sel;
      logic [127:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   edges   = 0;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   e0, e1;

   ctrl_pipe #(.STAGES(STAGES), .CW(CW), .RW(RW)) dut (
      .clk(clk), .reset(reset), .d_ctrl(d_ctrl), .d_valid(d_valid),
      .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rs_use(d_rs_use),
      .d_we(d_we), .d_load(d_load), .d_cond(d_cond), .d_not(d_not),
      .cmp_true(cmp_true), .stall(stall), .flush(flush),
      .ctrl_out(ctrl_out), .valid_out(valid_out), .we_out(we_out),
      .rd_out(rd_out), .taken(taken), .taken_q(taken_q), .load_use(load_use)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edges <= edges + 1;

   function automatic logic [CW-1:0] ctrl_of(input logic [RW-1:0] rd);
      return {8'h5A, 11'h000, rd};
   endfunction

   function automatic logic [127:0] act(input int sel);
      logic [127:0] a;
      a = '0;
      case (sel)
         SEL_VALID: a[STAGES-1:0]      = valid_out;
         SEL_WE:    a[STAGES-1:0]      = we_out;
         SEL_RD:    a[STAGES*RW-1:0]   = rd_out;
         SEL_CTRL:  a[STAGES*CW-1:0]   = ctrl_out;
         SEL_TQ:    a[STAGES-1:0]      = taken_q;
         SEL_TAKEN: a[0]               = taken;
         SEL_LU:    a[0]               = load_use;
         SEL_RD2:   a[RW-1:0]          = rd_out[2*RW +: RW];
         SEL_WE2:   a[0]               = we_out[2];
         default:   a                  = '1;
      endcase
      return a;
   endfunction

   function automatic void push_exp(input int cyc, input string nm, input int sel,
                                    input logic [127:0] v);
      exp_t e;
      e.cyc = cyc; e.nm = nm; e.sel = sel; e.val = v;
      sb_q.push_back(e);
   endfunction

   // Monitor: compare every expectation due at this edge, flag any that were missed.
   always @(negedge clk) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].cyc == edges) begin
            n_checks++;
            if (act(sb_q[i].sel) === sb_q[i].val) begin
               n_pass++;
            end else begin
               $display("FAIL %s @edge %0d: got %0h expected %0h",
                        sb_q[i].nm, edges, act(sb_q[i].sel), sb_q[i].val);
            end
            sb_q.delete(i);
         end else if (sb_q[i].cyc < edges) begin
            n_checks++;
            $display("FAIL %s: stale expectation for edge %0d seen at %0d, got none expected %0h",
                     sb_q[i].nm, sb_q[i].cyc, edges, sb_q[i].val);
            sb_q.delete(i);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      d_valid = 1'b0; d_ctrl = '0; d_rd = '0; d_rs1 = '0; d_rs2 = '0;
      d_rs_use = 2'b00; d_we = 1'b0; d_load = 1'b0; d_cond = 1'b0; d_not = 1'b0;
   endtask

   task automatic alu(input logic [RW-1:0] rd);
      idle_in();
      d_valid = 1'b1; d_ctrl = ctrl_of(rd); d_rd = rd; d_we = 1'b1;
   endtask

   task automatic ld(input logic [RW-1:0] rd);
      alu(rd);
      d_load = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

   initial begin
      // Reset with a live, hazard-shaped instruction on decode
      reset = 1'b0; stall = '0; flush = '0; cmp_true = 1'b0;
      ld(5'd5); d_rs1 = 5'd5; d_rs_use = 2'b01; d_cond = 1'b1;
      step(); // edge 1
      push_exp(edges, "rst_valid", SEL_VALID, 128'd0);
      push_exp(edges, "rst_rd",    SEL_RD,    128'd0);
      push_exp(edges, "rst_ctrl",  SEL_CTRL,  128'd0);
      push_exp(edges, "rst_tq",    SEL_TQ,    128'd0);
      push_exp(edges, "rst_lu",    SEL_LU,    128'd0);
      push_exp(edges, "rst_taken", SEL_TAKEN, 128'd0);
      reset = 1'b1; idle_in();
      step(); step();

      // Four ALU ops streamed back to back
      e0 = edges;
      for (int i = 1; i <= 4; i++) begin
         push_exp(e0 + i + 2, "wb_rd", SEL_RD2, 128'(i));
         push_exp(e0 + i + 2, "wb_we", SEL_WE2, 128'd1);
      end
      push_exp(e0 + 3, "stream_ctrl", SEL_CTRL,
               {56'd0, ctrl_of(5'd1), ctrl_of(5'd2), ctrl_of(5'd3)});
      push_exp(e0 + 7, "drain_valid", SEL_VALID, 128'd0);
      for (int i = 1; i <= 4; i++) begin
         alu(5'(i));
         step();
      end
      idle_in(); step(); step(); step();

      // Stall stage 1 for one edge with Z, A, B in flight
      e0 = edges;
      alu(5'd9); step(); alu(5'd6); step(); alu(5'd7); step();
      push_exp(e0 + 3, "pre_stall_rd", SEL_RD, 128'd9415);
      alu(5'd8); stall = 3'b010; step();
      push_exp(e0 + 4, "stall_valid", SEL_VALID, 128'd3);
      push_exp(e0 + 4, "stall_rd",    SEL_RD,    128'd199);
      push_exp(e0 + 4, "stall_we",    SEL_WE,    128'd3);
      stall = 3'b000; step();
      push_exp(e0 + 5, "resume_valid", SEL_VALID, 128'd7);
      push_exp(e0 + 5, "resume_rd",    SEL_RD,    128'd6376);
      idle_in(); step(); step(); step();

      // Load-use on rs1, then the same pattern with rd = 0
      e0 = edges;
      ld(5'd5); step();
      alu(5'd10); d_rs1 = 5'd5; d_rs_use = 2'b01;
      push_exp(e0 + 1, "lu_hit", SEL_LU, 128'd1);
      step();
      push_exp(e0 + 2, "lu_bubble_valid", SEL_VALID, 128'd2);
      push_exp(e0 + 2, "lu_bubble_rd",    SEL_RD,    128'd160);
      push_exp(e0 + 2, "lu_cleared",      SEL_LU,    128'd0);
      step();
      push_exp(e0 + 3, "lu_after_valid", SEL_VALID, 128'd5);
      push_exp(e0 + 3, "lu_after_rd",    SEL_RD,    128'd5130);
      idle_in(); step(); step(); step();

      e1 = edges;
      ld(5'd0); step();
      alu(5'd10); d_rs1 = 5'd0; d_rs_use = 2'b01;
      push_exp(e1 + 1, "lu_r0", SEL_LU, 128'd0);
      step();
      push_exp(e1 + 2, "lu_r0_valid", SEL_VALID, 128'd3);
      push_exp(e1 + 2, "lu_r0_rd",    SEL_RD,    128'd10);
      ld(5'd3); step();
      alu(5'd11); d_rs1 = 5'd4; d_rs2 = 5'd3; d_rs_use = 2'b10;
      push_exp(e1 + 3, "lu_rs2", SEL_LU, 128'd1);
      step();
      idle_in(); step(); step(); step();

      // BNE: not-equal taken, then equal not taken
      e0 = edges;
      idle_in(); d_valid = 1'b1; d_cond = 1'b1; d_not = 1'b1; d_ctrl = ctrl_of(5'd0);
      step();
      cmp_true = 1'b0;
      push_exp(e0 + 1, "bne_taken", SEL_TAKEN, 128'd1);
      step();
      cmp_true = 1'b1; idle_in();
      push_exp(e0 + 2, "bne_eq_not_taken", SEL_TAKEN, 128'd0);
      push_exp(e0 + 2, "bne_tq1",          SEL_TQ,    128'd2);
      step();
      push_exp(e0 + 3, "bne_tq2",   SEL_TQ,    128'd4);
      push_exp(e0 + 3, "bne_valid", SEL_VALID, 128'd6);
      push_exp(e0 + 3, "bne_we",    SEL_WE,    128'd0);
      cmp_true = 1'b0; step(); step(); step();

      // Flush stages 0,1 while stage 0 is also stalled
      e0 = edges;
      alu(5'd11); step(); alu(5'd12); step(); alu(5'd13); step();
      push_exp(e0 + 3, "full_valid", SEL_VALID, 128'd7);
      push_exp(e0 + 3, "full_rd",    SEL_RD,    128'd11661);
      alu(5'd14); flush = 3'b011; stall = 3'b001; step();
      push_exp(e0 + 4, "flush_valid", SEL_VALID, 128'd4);
      push_exp(e0 + 4, "flush_rd",    SEL_RD,    128'd12288);
      push_exp(e0 + 4, "flush_ctrl",  SEL_CTRL,  {56'd0, ctrl_of(5'd12), 24'd0, 24'd0});
      flush = 3'b000; stall = 3'b000; idle_in(); step(); step(); step();

      // Reset while full, stalled and flushing
      e0 = edges;
      alu(5'd15); step(); alu(5'd16); step(); alu(5'd17); step();
      alu(5'd18); stall = 3'b100; step();
      push_exp(e0 + 4, "held_valid", SEL_VALID, 128'd7);
      push_exp(e0 + 4, "held_rd",    SEL_RD,    128'd15889);
      step();
      reset = 1'b0; flush = 3'b111;
      push_exp(e0 + 5, "mid_rst_valid", SEL_VALID, 128'd0);
      push_exp(e0 + 5, "mid_rst_we",    SEL_WE,    128'd0);
      push_exp(e0 + 5, "mid_rst_rd",    SEL_RD,    128'd0);
      push_exp(e0 + 5, "mid_rst_ctrl",  SEL_CTRL,  128'd0);
      step();
      push_exp(e0 + 6, "rst_hold_valid", SEL_VALID, 128'd0);
      reset = 1'b1; stall = 3'b000; flush = 3'b000; alu(5'd19); step();
      push_exp(e0 + 7, "post_rst_valid", SEL_VALID, 128'd1);
      push_exp(e0 + 7, "post_rst_rd",    SEL_RD,    128'd19);
      idle_in(); step();
      push_exp(e0 + 8, "post_rst_adv", SEL_VALID, 128'd2);
      step(); step();

      while (sb_q.size() > 0) begin
         n_checks++;
         $display("FAIL %s: got no check expected one at edge %0d", sb_q[0].nm, sb_q[0].cyc);
         void'(sb_q.pop_front());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
